// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared types and VGA 640x480@60 defaults for the vdp scanout path
package vdp_pkg;

   localparam int CW = 12;
   typedef logic [CW-1:0] cnt_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Raster position plus the per-pixel timing flags derived from it
   typedef struct packed {
      cnt_t h;
      cnt_t v;
      logic pix_ce;
      logic active;
      logic hs_act;
      logic vs_act;
      logic wrap;
   } vdp_tim_t;

   localparam int VGA_CLK_DIV  = 2;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/vdp_timing.sv
// rtl/vdp_timing.sv - pixel clock divider, raster counters, sync/active flags and frame pulse
module vdp_timing
   import vdp_pkg::*;
#(
   parameter int CLK_DIV  = VGA_CLK_DIV,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
) (
   input  logic     i_clk,
   input  logic     i_rst,
   output vdp_tim_t o_tim,
   output logic     o_vga_clk,
   output logic     o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = $clog2(CLK_DIV);

   logic [DW-1:0] r_div;
   logic [DW-1:0] w_div_nxt;
   cnt_t          r_h;
   cnt_t          r_v;
   logic          r_vga_clk;
   logic          r_frame_start;
   logic          w_pix_ce;
   logic          w_h_last;
   logic          w_v_last;

   always_comb begin
      w_pix_ce  = (r_div == DW'(CLK_DIV - 1));
      w_div_nxt = w_pix_ce ? '0 : DW'(r_div + 1'b1);
      w_h_last  = (r_h == cnt_t'(H_TOTAL - 1));
      w_v_last  = (r_v == cnt_t'(V_TOTAL - 1));
   end

   // VGA_CLK is registered from the next divider value so it tracks div_cnt without lag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div         <= '0;
         r_h           <= '0;
         r_v           <= '0;
         r_vga_clk     <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_div         <= w_div_nxt;
         r_vga_clk     <= (w_div_nxt >= DW'(CLK_DIV / 2));
         r_frame_start <= w_pix_ce && w_h_last && w_v_last;
         if (w_pix_ce) begin
            r_h <= w_h_last ? '0 : cnt_t'(r_h + 1'b1);
            if (w_h_last) begin
               r_v <= w_v_last ? '0 : cnt_t'(r_v + 1'b1);
            end
         end
      end
   end

   always_comb begin
      o_tim        = '0;
      o_tim.h      = r_h;
      o_tim.v      = r_v;
      o_tim.pix_ce = w_pix_ce;
      o_tim.active = (r_h < cnt_t'(H_ACTIVE)) && (r_v < cnt_t'(V_ACTIVE));
      o_tim.hs_act = (r_h >= cnt_t'(H_ACTIVE + H_FP)) && (r_h < cnt_t'(H_ACTIVE + H_FP + H_SYNC));
      o_tim.vs_act = (r_v >= cnt_t'(V_ACTIVE + V_FP)) && (r_v < cnt_t'(V_ACTIVE + V_FP + V_SYNC));
      o_tim.wrap   = w_pix_ce && w_h_last && w_v_last;
   end

   assign o_vga_clk     = r_vga_clk;
   assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vdp_scanout.sv
// rtl/vdp_scanout.sv - centred, pixel-replicated framebuffer scanout driving an ADV7123-style VGA DAC
module vdp_scanout
   import vdp_pkg::*;
#(
   parameter int          CLK_DIV    = VGA_CLK_DIV,
   parameter int          H_ACTIVE   = VGA_H_ACTIVE,
   parameter int          H_FP       = VGA_H_FP,
   parameter int          H_SYNC     = VGA_H_SYNC,
   parameter int          H_BP       = VGA_H_BP,
   parameter int          V_ACTIVE   = VGA_V_ACTIVE,
   parameter int          V_FP       = VGA_V_FP,
   parameter int          V_SYNC     = VGA_V_SYNC,
   parameter int          V_BP       = VGA_V_BP,
   parameter bit          HS_POL     = 1'b0,
   parameter bit          VS_POL     = 1'b0,
   parameter int          FB_W       = 256,
   parameter int          FB_H       = 240,
   parameter int          SCALE      = 2,
   parameter int          AW         = 16,
   parameter int          RD_LAT     = 1,
   parameter logic [23:0] BORDER_RGB = 24'h000000
) (
   input  logic          CLOCK_50,
   input  logic          rst,
   output logic [AW-1:0] fb_radr,
   output logic          fb_re,
   input  logic [23:0]   fb_q,
   output logic          VGA_CLK,
   output logic [7:0]    VGA_R,
   output logic [7:0]    VGA_G,
   output logic [7:0]    VGA_B,
   output logic          VGA_BLANK_N,
   output logic          VGA_SYNC_N,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          frame_start
);

   localparam int WIN_W = FB_W * SCALE;
   localparam int WIN_H = FB_H * SCALE;
   localparam int H_OFF = (H_ACTIVE - WIN_W) / 2;
   localparam int V_OFF = (V_ACTIVE - WIN_H) / 2;
   localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

   if (CLK_DIV < 2 || CLK_DIV <= RD_LAT) begin : g_bad_cfg
      $error("vdp_scanout: CLK_DIV must be >= 2 and greater than RD_LAT");
   end

   vdp_tim_t w_tim;
   cnt_t     w_hrel;
   cnt_t     w_vrel;
   logic     w_in_win;
   logic     w_last_col;

   logic [AW-1:0] r_row_base;
   logic [AW-1:0] r_x;
   logic [SW-1:0] r_xsub;
   logic [SW-1:0] r_ysub;

   logic [AW-1:0] r_fb_radr;
   logic          r_fb_re;
   logic          r_act1;
   logic          r_win1;
   logic          r_hs1;
   logic          r_vs1;

   rgb_t          r_rgb;
   logic          r_blank_n;
   logic          r_hs;
   logic          r_vs;

   vdp_timing #(
      .CLK_DIV (CLK_DIV),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .i_clk        (CLOCK_50),
      .i_rst        (rst),
      .o_tim        (w_tim),
      .o_vga_clk    (VGA_CLK),
      .o_frame_start(frame_start)
   );

   // Offsets wrap to large values left of / above the window, so one compare per axis suffices
   always_comb begin
      w_hrel     = cnt_t'(w_tim.h - cnt_t'(H_OFF));
      w_vrel     = cnt_t'(w_tim.v - cnt_t'(V_OFF));
      w_in_win   = (w_hrel < cnt_t'(WIN_W)) && (w_vrel < cnt_t'(WIN_H));
      w_last_col = (w_hrel == cnt_t'(WIN_W - 1));
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst || w_tim.wrap) begin
         r_row_base <= '0;
         r_x        <= '0;
         r_xsub     <= '0;
         r_ysub     <= '0;
      end else if (w_tim.pix_ce && w_in_win) begin
         if (w_last_col) begin
            r_x    <= '0;
            r_xsub <= '0;
            if (r_ysub == SW'(SCALE - 1)) begin
               r_ysub     <= '0;
               r_row_base <= r_row_base + AW'(FB_W);
            end else begin
               r_ysub <= r_ysub + 1'b1;
            end
         end else if (r_xsub == SW'(SCALE - 1)) begin
            r_xsub <= '0;
            r_x    <= r_x + 1'b1;
         end else begin
            r_xsub <= r_xsub + 1'b1;
         end
      end
   end

   // P1 issues the read, P2 latches fb_q one full pixel later
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         r_fb_radr <= '0;
         r_fb_re   <= 1'b0;
         r_act1    <= 1'b0;
         r_win1    <= 1'b0;
         r_hs1     <= 1'b0;
         r_vs1     <= 1'b0;
         r_rgb     <= '0;
         r_blank_n <= 1'b0;
         r_hs      <= !HS_POL;
         r_vs      <= !VS_POL;
      end else if (w_tim.pix_ce) begin
         r_fb_re <= w_in_win;
         r_act1  <= w_tim.active;
         r_win1  <= w_in_win;
         r_hs1   <= w_tim.hs_act;
         r_vs1   <= w_tim.vs_act;
         if (w_in_win) begin
            r_fb_radr <= r_row_base + r_x;
         end
         if (r_act1 && r_win1) begin
            r_rgb <= rgb_t'(fb_q);
         end else if (r_act1) begin
            r_rgb <= rgb_t'(BORDER_RGB);
         end else begin
            r_rgb <= '0;
         end
         r_blank_n <= r_act1;
         r_hs      <= r_hs1 ? HS_POL : !HS_POL;
         r_vs      <= r_vs1 ? VS_POL : !VS_POL;
      end
   end

   assign fb_radr     = r_fb_radr;
   assign fb_re       = r_fb_re;
   assign VGA_R       = r_rgb.r;
   assign VGA_G       = r_rgb.g;
   assign VGA_B       = r_rgb.b;
   assign VGA_BLANK_N = r_blank_n;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_HS      = r_hs;
   assign VGA_VS      = r_vs;

endmodule
